// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
//
// Port 0 (CPU load/store) and port 1 (debug/DMA) each issue word requests.
// At most one transaction is in flight. Each transaction goes IDLE -> ACCESS
// -> RESP, so the arbiter handles one access every three cycles. When both
// ports request at once, the port that was not granted last wins.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   reqN, weN, addrN,     request, write enable, word address and write data
//   wdataN                for port N; held stable until ackN
//   ackN, errN, rdataN    one-cycle completion, out-of-range flag, read data
//   MemRead, MemWrite     memory strobes, asserted only during ACCESS
//   ALUOut, reg2data      memory address and write data (0 outside ACCESS)
//   memout                memory read data, combinational from ALUOut/MemRead
module dmem_arbiter #(
  parameter int DEPTH = 200,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata0,
  input  logic [31:0]   wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err0,
  output logic          err1,
  output logic [31:0]   rdata0,
  output logic [31:0]   rdata1,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] ALUOut,
  output logic [31:0]   reg2data,
  input  logic [31:0]   memout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state_q;
  logic          sel_q, last_q;
  logic          we_q, in_range_q;
  logic          mem_read_q, mem_write_q;
  logic [AW-1:0] alu_out_q;
  logic [31:0]   reg2data_q;
  logic          ack0_q, ack1_q, err0_q, err1_q;
  logic [31:0]   rdata0_q, rdata1_q;

  // Grant decision and the granted port's request fields.
  logic          sel_d;
  logic [AW-1:0] g_addr;
  logic [31:0]   g_wdata;
  logic          g_we;
  logic          g_in_range;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    sel_d = sel_q;
    if (req0 && !req1)      sel_d = 1'b0;
    else if (req1 && !req0) sel_d = 1'b1;
    else if (req0 && req1)  sel_d = ~last_q;   // tie: alternate with last grant

    g_addr     = sel_d ? addr1  : addr0;
    g_wdata    = sel_d ? wdata1 : wdata0;
    g_we       = sel_d ? we1    : we0;
    g_in_range = ({1'b0, g_addr} < DEPTH_W);
  end

  // NOTE: all state below is sequential and updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      last_q      <= 1'b1;                     // port 0 wins the first tie
      we_q        <= 1'b0;
      in_range_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_out_q   <= '0;
      reg2data_q  <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q     <= ACCESS;
            sel_q       <= sel_d;
            last_q      <= sel_d;
            we_q        <= g_we;
            in_range_q  <= g_in_range;
            // Strobes, address and data are registered on grant so they are
            // clean for the whole ACCESS cycle; out-of-range never strobes.
            mem_write_q <= g_we & g_in_range;
            mem_read_q  <= ~g_we & g_in_range;
            alu_out_q   <= g_addr;
            reg2data_q  <= g_wdata;
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          alu_out_q   <= '0;
          reg2data_q  <= '0;
          // Reads capture memout (or 0 when out of range); writes keep rdata.
          if (sel_q) begin
            ack1_q <= 1'b1;
            err1_q <= ~in_range_q;
            if (!we_q) rdata1_q <= in_range_q ? memout : 32'h0;
          end else begin
            ack0_q <= 1'b1;
            err0_q <= ~in_range_q;
            if (!we_q) rdata0_q <= in_range_q ? memout : 32'h0;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign MemRead  = mem_read_q;
  // The memory commits on the same edge that samples reset, so the write
  // strobe is masked by reset directly to abort a write in flight.
  assign MemWrite = mem_write_q & ~reset;
  assign ALUOut   = alu_out_q;
  assign reg2data = reg2data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a
// bench-side memory and an independent expected-memory model.
module tb_dmem_arbiter;

  localparam int          DEPTH   = 200;
  localparam logic [31:0] DEPTH_L = 32'd200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic [31:0] rdata [2];
  logic        MemRead, MemWrite;
  logic [31:0] ALUOut, reg2data, memout;

  logic [31:0] mem     [DEPTH];   // attached memory
  logic [31:0] exp_mem [DEPTH];   // expected contents

  int tests = 0;
  int fails = 0;
  int n_wr = 0, n_rd = 0;
  logic [31:0] wr_addr, wr_data, rd_addr;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .ack0(ack[0]), .ack1(ack[1]), .err0(err[0]), .err1(err[1]),
    .rdata0(rdata[0]), .rdata1(rdata[1]),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOut(ALUOut),
    .reg2data(reg2data), .memout(memout)
  );

  always #5 clk = ~clk;

  assign memout = (MemRead && ALUOut < DEPTH_L) ? mem[ALUOut[7:0]] : 32'h0;

  always @(posedge clk)
    if (MemWrite && ALUOut < DEPTH_L) mem[ALUOut[7:0]] <= reg2data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-cycle invariants and strobe recording.
  always @(negedge clk) begin
    check("rd_wr_excl", 32'(MemRead & MemWrite), 0);
    check("wr_in_range", 32'(MemWrite && ALUOut >= DEPTH_L), 0);
    check("ack_excl", 32'(ack[0] & ack[1]), 0);
    if (MemWrite) begin n_wr++; wr_addr = ALUOut; wr_data = reg2data; end
    if (MemRead)  begin n_rd++; rd_addr = ALUOut; end
  end

  // One transaction on port p. With chk_lat the DUT must be idle at entry
  // and the ack must arrive on the second falling edge after the request.
  task automatic txn(input int p, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input bit chk_lat);
    logic [31:0] prev, exp_rd;
    logic        exp_err;
    int          cyc;
    bit          got;
    if (chk_lat) @(negedge clk);
    prev = rdata[p];
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
    cyc = 0; got = 0;
    while (!got && cyc < 6) begin
      @(negedge clk);
      cyc++;
      if (ack[p]) got = 1;
    end
    req[p] = 1'b0;
    check($sformatf("p%0d_ack_within_6", p), 32'(got), 1);
    if (got) begin
      exp_err = (a >= DEPTH_L);
      exp_rd  = w ? prev : (exp_err ? 32'h0 : exp_mem[a[7:0]]);
      check($sformatf("p%0d_err_a%0d", p, a), 32'(err[p]), 32'(exp_err));
      check($sformatf("p%0d_rdata_a%0d", p, a), rdata[p], exp_rd);
      if (w && !exp_err) exp_mem[a[7:0]] = d;
      if (chk_lat) check($sformatf("p%0d_latency", p), cyc, 2);
    end
  endtask

  task automatic port_traffic(input int p, input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 215)), $urandom, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev_port[$];
    int ev_cyc[$];
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'hA000_0000 | 32'(i);
      exp_mem[i] = 32'hA000_0000 | 32'(i);
    end
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; we[p] = 0; addr[p] = 0; wdata[p] = 0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_ack0", 32'(ack[0]), 0);
    check("rst_ack1", 32'(ack[1]), 0);
    check("rst_err0", 32'(err[0]), 0);
    check("rst_err1", 32'(err[1]), 0);
    check("rst_rdata0", rdata[0], 0);
    check("rst_rdata1", rdata[1], 0);
    check("rst_strobes", {30'h0, MemRead, MemWrite}, 0);
    check("rst_aluout", ALUOut, 0);
    check("rst_reg2data", reg2data, 0);

    // Port 0 write then read of address 5.
    n_wr = 0;
    txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1);
    check("wr5_strobe_cycles", n_wr, 1);
    check("wr5_aluout", wr_addr, 5);
    check("wr5_reg2data", wr_data, 32'hDEAD_BEEF);
    check("wr5_mem", mem[5], 32'hDEAD_BEEF);
    n_rd = 0;
    txn(0, 1'b0, 32'd5, 32'h0, 1);
    check("rd5_strobe_cycles", n_rd, 1);
    check("rd5_aluout", rd_addr, 5);

    // Port 1 boundary: 199 in range, 250 write and 200 read out of range.
    txn(1, 1'b0, 32'd199, 32'h0, 1);
    check("p0_rdata_kept", rdata[0], 32'hDEAD_BEEF);
    n_wr = 0;
    txn(1, 1'b1, 32'd250, 32'h5555_AAAA, 1);
    check("wr250_no_strobe", n_wr, 0);
    n_rd = 0;
    txn(1, 1'b0, 32'd200, 32'h0, 1);
    check("rd200_no_strobe", n_rd, 0);

    // Request dropped during ACCESS still completes.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'd10;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    check("drop_ack1", 32'(ack[1]), 1);
    check("drop_rdata1", rdata[1], exp_mem[10]);

    // Tie after reset: grants alternate 0,1,0,1 with both held.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req[0] = 1; we[0] = 0; addr[0] = 32'd1;
    req[1] = 1; we[1] = 0; addr[1] = 32'd2;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack[0]) begin ev_port.push_back(0); ev_cyc.push_back(c); end
      if (ack[1]) begin ev_port.push_back(1); ev_cyc.push_back(c); end
    end
    req[0] = 0; req[1] = 0;
    check("tie_ack_count", ev_port.size(), 4);
    if (ev_port.size() == 4)
      for (int k = 0; k < 4; k++) begin
        check($sformatf("tie_port_%0d", k), ev_port[k], k % 2);
        check($sformatf("tie_cycle_%0d", k), ev_cyc[k], 2 + 3 * k);
      end
    check("tie_rdata0", rdata[0], exp_mem[1]);
    check("tie_rdata1", rdata[1], exp_mem[2]);

    // Reset during an ACCESS write aborts it.
    @(negedge clk);
    req[0] = 1; we[0] = 1; addr[0] = 32'd7; wdata[0] = 32'h1234_5678;
    @(negedge clk);
    check("abort_wr_strobe_before", 32'(MemWrite), 1);
    reset = 1'b1; req[0] = 0;
    #1;
    check("abort_wr_masked", 32'(MemWrite), 0);
    @(negedge clk);
    reset = 1'b0;
    check("abort_ack0", 32'(ack[0]), 0);
    check("abort_outputs", {30'h0, MemRead, MemWrite} | ALUOut | reg2data, 0);
    check("abort_rdata0", rdata[0], 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_late_ack", 32'(ack[0]), 0);
    end
    check("abort_mem7", mem[7], 32'hA000_0007);
    txn(0, 1'b0, 32'd7, 32'h0, 1);

    // Random traffic on both ports against the expected-memory model.
    fork
      port_traffic(0, 1500);
      port_traffic(1, 1500);
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
